flr_req_initiator: RTL and testbench
====================================

Name: flr_req_initiator

Overview:
- Initiator end of the FLR request/response sideband. Consumes the per-link `flr_rsp` that the FLR reset manager produces.
- Used on the PCIe-subsystem side of the port gasket, and as the FLR driver in the gasket bench.
- Accepts FLR commands (PF, or VF within a PF) and issues one-cycle `flr_req` beats. Tracks each outstanding FLR in a small table.
- Retires each entry on its matching `flr_rsp` or on timeout, and reports completion status per command.

Parameters:
- NUM_PF, 1, number of PFs on the link; PF_W = max(1, $clog2(NUM_PF)).
- MAX_NUM_VF, 1, max VFs per PF; VF_W = max(1, $clog2(MAX_NUM_VF)).
- MAX_OUTSTANDING, 4, tracking-table depth (1..16).
- TIMEOUT_CYCLES, 65535, cycles from issue to timeout (≥2); TMR_W = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  FLR command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_pf  in  PF_W  target PF.
- cmd_vf  in  VF_W  target VF; ignored if cmd_vf_active=0.
- cmd_vf_active  in  1  1 = VF FLR, 0 = PF FLR.
- flr_req_tvalid  out  1  one-cycle FLR request beat.
- flr_req_pf / flr_req_vf / flr_req_vf_active  out  PF_W / VF_W / 1  request fields.
- flr_rsp_tvalid  in  1  FLR completion beat; no backpressure.
- flr_rsp_pf / flr_rsp_vf / flr_rsp_vf_active  in  PF_W / VF_W / 1  response fields.
- done_valid  out  1  one-cycle completion report.
- done_pf / done_vf / done_vf_active  out  PF_W / VF_W / 1  completed function.
- done_status  out  2  00 OK, 01 TIMEOUT, 10 DUPLICATE.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  entries in PENDING or EXPIRED.
- err_unexp_rsp  out  1  sticky: a response matched no entry.
- err_clear  in  1  clears err_unexp_rsp.
- stat_issued / stat_ok / stat_timeout  out  32 each  optional statistics (see Optional Feature).

Behaviour:
- Reset:
  - All outputs 0 and all entries IDLE.
  - Reset mid-operation drops every outstanding entry silently: no done reports and no late requests.
- Per-entry states: IDLE, PENDING, EXPIRED.
  - IDLE→PENDING on allocation.
  - PENDING→IDLE on matching response.
  - PENDING→EXPIRED when timer == TIMEOUT_CYCLES-1.
  - EXPIRED→IDLE when its TIMEOUT report wins the done slot.
- Key comparison:
  - Entries match on {pf, vf_active, vf}.
  - vf is compared only when vf_active=1; for PF keys vf is stored as 0.
- cmd_ready = (some entry IDLE) && !flr_rsp_tvalid, so a response and an acceptance never coincide.
- Accept, key not outstanding:
  - Allocate the lowest-index IDLE entry with timer=0.
  - Next cycle: flr_req_tvalid=1 for exactly one cycle with the command fields.
  - Back-to-back accepts give back-to-back beats.
- Accept, key already PENDING or EXPIRED:
  - No entry allocated and no request issued.
  - Next cycle: done_valid=1 with status DUPLICATE.
- Matching response:
  - Entry goes IDLE; next cycle done_valid=1, status OK, with the response fields.
  - A response in the same cycle the timer reaches its limit: response wins, status OK.
  - A response for an EXPIRED entry is unmatched: entry stays EXPIRED and err_unexp_rsp is set.
- Unmatched response: err_unexp_rsp=1 next cycle.
  - Holds until err_clear.
  - err_clear in the same cycle as a new unmatched response leaves the bit at 1.
- Timers:
  - PENDING timers increment every cycle.
  - EXPIRED entries hold until granted.
- Done slot, one report per cycle, priority: response OK > DUPLICATE > TIMEOUT (lowest-index EXPIRED entry).
  - OK and DUPLICATE cannot coincide, per cmd_ready.
- outstanding updates one cycle after each allocation/free.
  - At MAX_OUTSTANDING, cmd_ready=0.
- Latency: command→request 1 cycle; response→done 1 cycle.

Optional Feature:
- Macro FLR_INIT_STATS_EN.
- Defined: stat_issued, stat_ok and stat_timeout are 32-bit saturating counters.
  - They increment on flr_req_tvalid, on done OK, and on done TIMEOUT respectively.
  - They clear on reset and saturate at 32'hFFFF_FFFF.
- Not defined: the counters are not built and all stat_* ports are tied to 0.

Test Plan:
- PF FLR: cmd pf=1, vf_active=0 → flr_req beat next cycle with pf=1; outstanding=1. Respond after 10 cycles → done OK pf=1 the following cycle; outstanding=0.
- Table fill: 4 VF cmds (pf=0, vf=0..3), MAX_OUTSTANDING=4 → 4 consecutive req beats, then cmd_ready=0. Respond vf=2 → done OK vf=2; cmd_ready returns to 1.
- Duplicate: cmd pf=0 vf=5 accepted, then same cmd again → second gets done DUPLICATE one cycle after accept; only one req beat total.
- Timeout: TIMEOUT_CYCLES=100, no response → done TIMEOUT exactly 101 cycles after the req beat. A later response for that key sets err_unexp_rsp; err_clear clears it.
- Collisions: response on the exact cycle the timer expires → done OK, no TIMEOUT. flr_rsp_tvalid with cmd_valid → cmd_ready=0 that cycle.
- Reset mid-run with 3 entries outstanding → outstanding=0, no done pulses. With FLR_INIT_STATS_EN, stat_issued=0 after reset.

Source files
------------

// File: rtl/flr_req_initiator.sv
// FLR request initiator: issues flr_req beats, tracks outstanding FLRs and reports OK/TIMEOUT/DUPLICATE.
// Define FLR_INIT_STATS_EN to build the saturating stat_issued/stat_ok/stat_timeout counters.
module flr_req_initiator #(
    parameter  int NUM_PF          = 1,
    parameter  int MAX_NUM_VF      = 1,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int TIMEOUT_CYCLES  = 65535,
    localparam int PF_W  = (NUM_PF > 1) ? $clog2(NUM_PF) : 1,
    localparam int VF_W  = (MAX_NUM_VF > 1) ? $clog2(MAX_NUM_VF) : 1,
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1),
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PF_W-1:0]  cmd_pf,
    input  logic [VF_W-1:0]  cmd_vf,
    input  logic             cmd_vf_active,
    output logic             flr_req_tvalid,
    output logic [PF_W-1:0]  flr_req_pf,
    output logic [VF_W-1:0]  flr_req_vf,
    output logic             flr_req_vf_active,
    input  logic             flr_rsp_tvalid,
    input  logic [PF_W-1:0]  flr_rsp_pf,
    input  logic [VF_W-1:0]  flr_rsp_vf,
    input  logic             flr_rsp_vf_active,
    output logic             done_valid,
    output logic [PF_W-1:0]  done_pf,
    output logic [VF_W-1:0]  done_vf,
    output logic             done_vf_active,
    output logic [1:0]       done_status,
    output logic [OUT_W-1:0] outstanding,
    output logic             err_unexp_rsp,
    input  logic             err_clear,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_ok,
    output logic [31:0]      stat_timeout
);

    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    localparam logic [1:0] DS_OK  = 2'b00;
    localparam logic [1:0] DS_TO  = 2'b01;
    localparam logic [1:0] DS_DUP = 2'b10;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q [MAX_OUTSTANDING];
    logic [1:0]       state_d [MAX_OUTSTANDING];
    logic [TMR_W-1:0] timer_q [MAX_OUTSTANDING];
    logic [TMR_W-1:0] timer_d [MAX_OUTSTANDING];
    logic [PF_W-1:0]  pf_q    [MAX_OUTSTANDING];
    logic [PF_W-1:0]  pf_d    [MAX_OUTSTANDING];
    logic [VF_W-1:0]  vf_q    [MAX_OUTSTANDING];
    logic [VF_W-1:0]  vf_d    [MAX_OUTSTANDING];
    logic             vfa_q   [MAX_OUTSTANDING];
    logic             vfa_d   [MAX_OUTSTANDING];

    logic             req_valid_q, req_vfa_q;
    logic [PF_W-1:0]  req_pf_q;
    logic [VF_W-1:0]  req_vf_q;

    logic             done_valid_q, done_valid_d;
    logic [PF_W-1:0]  done_pf_q, done_pf_d;
    logic [VF_W-1:0]  done_vf_q, done_vf_d;
    logic             done_vfa_q, done_vfa_d;
    logic [1:0]       done_status_q, done_status_d;

    logic [OUT_W-1:0] out_q, out_d;
    logic             err_q, err_d;

    logic [VF_W-1:0]  cmd_vf_n, rsp_vf_n;
    logic             any_idle, exp_any, cmd_hit, rsp_hit;
    logic [IDX_W-1:0] alloc_idx, exp_idx, rsp_idx;
    logic             accept, do_alloc, do_dup, rsp_ok, rsp_unexp, to_grant;

    function automatic logic key_eq(
        input logic [PF_W-1:0] pa, input logic va, input logic [VF_W-1:0] fa,
        input logic [PF_W-1:0] pb, input logic vb, input logic [VF_W-1:0] fb
    );
        return (pa == pb) && (va == vb) && (fa == fb);
    endfunction

    // PF keys carry vf=0 so a plain equality compare on {pf, vf_active, vf} suffices.
    assign cmd_vf_n = cmd_vf_active ? cmd_vf : '0;
    assign rsp_vf_n = flr_rsp_vf_active ? flr_rsp_vf : '0;

    always_comb begin
        any_idle  = 1'b0;
        alloc_idx = '0;
        exp_any   = 1'b0;
        exp_idx   = '0;
        cmd_hit   = 1'b0;
        rsp_hit   = 1'b0;
        rsp_idx   = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (state_q[i] == ST_IDLE) begin
                any_idle  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
            if (state_q[i] == ST_EXPIRED) begin
                exp_any = 1'b1;
                exp_idx = IDX_W'(i);
            end
            if (state_q[i] != ST_IDLE &&
                key_eq(pf_q[i], vfa_q[i], vf_q[i], cmd_pf, cmd_vf_active, cmd_vf_n))
                cmd_hit = 1'b1;
            if (state_q[i] == ST_PENDING &&
                key_eq(pf_q[i], vfa_q[i], vf_q[i], flr_rsp_pf, flr_rsp_vf_active, rsp_vf_n)) begin
                rsp_hit = 1'b1;
                rsp_idx = IDX_W'(i);
            end
        end
    end

    assign cmd_ready = any_idle && !flr_rsp_tvalid && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign do_alloc  = accept && !cmd_hit;
    assign do_dup    = accept && cmd_hit;
    assign rsp_ok    = flr_rsp_tvalid && rsp_hit;
    assign rsp_unexp = flr_rsp_tvalid && !rsp_hit;
    assign to_grant  = exp_any && !rsp_ok && !do_dup;

    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            pf_d[i]    = pf_q[i];
            vf_d[i]    = vf_q[i];
            vfa_d[i]   = vfa_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (do_alloc && alloc_idx == IDX_W'(i)) begin
                        state_d[i] = ST_PENDING;
                        timer_d[i] = '0;
                        pf_d[i]    = cmd_pf;
                        vf_d[i]    = cmd_vf_n;
                        vfa_d[i]   = cmd_vf_active;
                    end
                end
                ST_PENDING: begin
                    // A response on the expiry cycle wins over the timeout.
                    if (rsp_ok && rsp_idx == IDX_W'(i))
                        state_d[i] = ST_IDLE;
                    else if (timer_q[i] == TMR_LAST)
                        state_d[i] = ST_EXPIRED;
                    else
                        timer_d[i] = timer_q[i] + TMR_W'(1);
                end
                ST_EXPIRED: begin
                    if (to_grant && exp_idx == IDX_W'(i))
                        state_d[i] = ST_IDLE;
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (state_d[i] != ST_IDLE) out_d = out_d + OUT_W'(1);
    end

    always_comb begin
        done_valid_d  = rsp_ok || do_dup || to_grant;
        done_pf_d     = '0;
        done_vf_d     = '0;
        done_vfa_d    = 1'b0;
        done_status_d = DS_OK;
        if (rsp_ok) begin
            done_pf_d  = flr_rsp_pf;
            done_vf_d  = rsp_vf_n;
            done_vfa_d = flr_rsp_vf_active;
        end else if (do_dup) begin
            done_pf_d     = cmd_pf;
            done_vf_d     = cmd_vf_n;
            done_vfa_d    = cmd_vf_active;
            done_status_d = DS_DUP;
        end else if (to_grant) begin
            done_pf_d     = pf_q[exp_idx];
            done_vf_d     = vf_q[exp_idx];
            done_vfa_d    = vfa_q[exp_idx];
            done_status_d = DS_TO;
        end
    end

    // A new unmatched response outranks a simultaneous clear.
    assign err_d = (err_q && !err_clear) || rsp_unexp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
                pf_q[i]    <= '0;
                vf_q[i]    <= '0;
                vfa_q[i]   <= 1'b0;
            end
            req_valid_q   <= 1'b0;
            req_pf_q      <= '0;
            req_vf_q      <= '0;
            req_vfa_q     <= 1'b0;
            done_valid_q  <= 1'b0;
            done_pf_q     <= '0;
            done_vf_q     <= '0;
            done_vfa_q    <= 1'b0;
            done_status_q <= DS_OK;
            out_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                pf_q[i]    <= pf_d[i];
                vf_q[i]    <= vf_d[i];
                vfa_q[i]   <= vfa_d[i];
            end
            req_valid_q <= do_alloc;
            if (do_alloc) begin
                req_pf_q  <= cmd_pf;
                req_vf_q  <= cmd_vf_n;
                req_vfa_q <= cmd_vf_active;
            end
            done_valid_q  <= done_valid_d;
            done_pf_q     <= done_pf_d;
            done_vf_q     <= done_vf_d;
            done_vfa_q    <= done_vfa_d;
            done_status_q <= done_status_d;
            out_q         <= out_d;
            err_q         <= err_d;
        end
    end

    assign flr_req_tvalid    = req_valid_q;
    assign flr_req_pf        = req_pf_q;
    assign flr_req_vf        = req_vf_q;
    assign flr_req_vf_active = req_vfa_q;
    assign done_valid        = done_valid_q;
    assign done_pf           = done_pf_q;
    assign done_vf           = done_vf_q;
    assign done_vf_active    = done_vfa_q;
    assign done_status       = done_status_q;
    assign outstanding       = out_q;
    assign err_unexp_rsp     = err_q;

`ifdef FLR_INIT_STATS_EN
    logic [31:0] stat_issued_q, stat_ok_q, stat_timeout_q;

    // Counted on the same events that load the req/done registers, so stats track the beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued_q  <= '0;
            stat_ok_q      <= '0;
            stat_timeout_q <= '0;
        end else begin
            if (do_alloc && stat_issued_q != 32'hFFFF_FFFF)
                stat_issued_q <= stat_issued_q + 32'd1;
            if (rsp_ok && stat_ok_q != 32'hFFFF_FFFF)
                stat_ok_q <= stat_ok_q + 32'd1;
            if (to_grant && stat_timeout_q != 32'hFFFF_FFFF)
                stat_timeout_q <= stat_timeout_q + 32'd1;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_ok      = stat_ok_q;
    assign stat_timeout = stat_timeout_q;
`else
    assign stat_issued  = '0;
    assign stat_ok      = '0;
    assign stat_timeout = '0;
`endif

endmodule

// File: tb/tb_flr_req_initiator.sv
// Bench for flr_req_initiator: directed test-plan steps then random traffic against a deadline-based table model.
module tb_flr_req_initiator;

    localparam int NPF  = 2;
    localparam int NVF  = 8;
    localparam int NOUT = 4;
    localparam int TMO  = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_vf_active;
    logic [0:0] cmd_pf;
    logic [2:0] cmd_vf;
    logic       flr_req_tvalid, flr_req_vf_active;
    logic [0:0] flr_req_pf;
    logic [2:0] flr_req_vf;
    logic       flr_rsp_tvalid, flr_rsp_vf_active;
    logic [0:0] flr_rsp_pf;
    logic [2:0] flr_rsp_vf;
    logic       done_valid, done_vf_active;
    logic [0:0] done_pf;
    logic [2:0] done_vf;
    logic [1:0] done_status;
    logic [2:0] outstanding;
    logic       err_unexp_rsp, err_clear;
    logic [31:0] stat_issued, stat_ok, stat_timeout;

    always #5 clk = ~clk;

    flr_req_initiator #(
        .NUM_PF(NPF), .MAX_NUM_VF(NVF), .MAX_OUTSTANDING(NOUT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pf(cmd_pf), .cmd_vf(cmd_vf),
        .cmd_vf_active(cmd_vf_active),
        .flr_req_tvalid(flr_req_tvalid), .flr_req_pf(flr_req_pf), .flr_req_vf(flr_req_vf),
        .flr_req_vf_active(flr_req_vf_active),
        .flr_rsp_tvalid(flr_rsp_tvalid), .flr_rsp_pf(flr_rsp_pf), .flr_rsp_vf(flr_rsp_vf),
        .flr_rsp_vf_active(flr_rsp_vf_active),
        .done_valid(done_valid), .done_pf(done_pf), .done_vf(done_vf),
        .done_vf_active(done_vf_active), .done_status(done_status),
        .outstanding(outstanding), .err_unexp_rsp(err_unexp_rsp), .err_clear(err_clear),
        .stat_issued(stat_issued), .stat_ok(stat_ok), .stat_timeout(stat_timeout)
    );

    int tests = 0;
    int fails = 0;

    // Model: each busy slot remembers its key and the cycle it was accepted in.
    bit m_busy [NOUT];
    int m_pf [NOUT], m_va [NOUT], m_vf [NOUT], m_iss [NOUT];
    int cyc;
    int m_issued, m_ok, m_to;
    bit e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit same(input int p1, a1, v1, p2, a2, v2);
        return (p1 == p2) && (a1 == a2) && (v1 == v2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NOUT; i++) m_busy[i] = 1'b0;
        e_err = 1'b0; m_issued = 0; m_ok = 0; m_to = 0;
    endtask

    task automatic quiet();
        cmd_valid = 1'b0; cmd_pf = '0; cmd_vf = '0; cmd_vf_active = 1'b0;
        flr_rsp_tvalid = 1'b0; flr_rsp_pf = '0; flr_rsp_vf = '0; flr_rsp_vf_active = 1'b0;
        err_clear = 1'b0;
    endtask

    // One clock: predict from the inputs currently driven, cross the edge, compare.
    task automatic tick();
        int cpf, cva, cvf, rpf, rva, rvf, hit, e, slot, nfree, nbusy;
        bit rdy, acc, dup, rq, dv;
        int dpf, dva, dvf, dst;
        #1;
        cpf = int'(cmd_pf); cva = int'(cmd_vf_active); cvf = cmd_vf_active ? int'(cmd_vf) : 0;
        rpf = int'(flr_rsp_pf); rva = int'(flr_rsp_vf_active);
        rvf = flr_rsp_vf_active ? int'(flr_rsp_vf) : 0;
        nfree = 0;
        for (int i = 0; i < NOUT; i++) if (!m_busy[i]) nfree++;
        rdy = (nfree > 0) && !flr_rsp_tvalid;
        chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
        acc = cmd_valid && rdy;
        hit = -1; dup = 1'b0; e = -1; slot = -1;
        for (int i = 0; i < NOUT; i++) begin
            if (m_busy[i] && flr_rsp_tvalid && cyc <= m_iss[i] + TMO &&
                same(m_pf[i], m_va[i], m_vf[i], rpf, rva, rvf)) hit = i;
            if (m_busy[i] && acc && same(m_pf[i], m_va[i], m_vf[i], cpf, cva, cvf)) dup = 1'b1;
            if (m_busy[i] && cyc >= m_iss[i] + TMO + 1 && e < 0) e = i;
            if (!m_busy[i] && slot < 0) slot = i;
        end
        dv = 1'b1; dpf = 0; dva = 0; dvf = 0; dst = 0;
        if (hit >= 0) begin
            dpf = rpf; dva = rva; dvf = rvf; dst = 0; m_busy[hit] = 1'b0; m_ok++;
        end else if (dup) begin
            dpf = cpf; dva = cva; dvf = cvf; dst = 2;
        end else if (e >= 0) begin
            dpf = m_pf[e]; dva = m_va[e]; dvf = m_vf[e]; dst = 1; m_busy[e] = 1'b0; m_to++;
        end else dv = 1'b0;
        rq = acc && !dup;
        if (rq) begin
            m_busy[slot] = 1'b1; m_pf[slot] = cpf; m_va[slot] = cva; m_vf[slot] = cvf;
            m_iss[slot] = cyc; m_issued++;
        end
        e_err = (e_err && !err_clear) || (flr_rsp_tvalid && hit < 0);
        nbusy = 0;
        for (int i = 0; i < NOUT; i++) if (m_busy[i]) nbusy++;
        @(posedge clk); #1;
        cyc++;
        chk("req_valid", 32'(flr_req_tvalid), 32'(rq));
        if (rq) begin
            chk("req_pf", 32'(flr_req_pf), 32'(cpf));
            chk("req_vfa", 32'(flr_req_vf_active), 32'(cva));
            chk("req_vf", 32'(flr_req_vf), 32'(cvf));
        end
        chk("done_valid", 32'(done_valid), 32'(dv));
        if (dv) begin
            chk("done_pf", 32'(done_pf), 32'(dpf));
            chk("done_vfa", 32'(done_vf_active), 32'(dva));
            chk("done_vf", 32'(done_vf), 32'(dvf));
            chk("done_status", 32'(done_status), 32'(dst));
        end
        chk("outstanding", 32'(outstanding), 32'(nbusy));
        chk("err_unexp", 32'(err_unexp_rsp), 32'(e_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cmd(input int p, input int a, input int v);
        cmd_valid = 1'b1; cmd_pf = 1'(p); cmd_vf_active = 1'(a); cmd_vf = 3'(v);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rsp(input int p, input int a, input int v);
        flr_rsp_tvalid = 1'b1; flr_rsp_pf = 1'(p); flr_rsp_vf_active = 1'(a); flr_rsp_vf = 3'(v);
        tick();
        flr_rsp_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_req_valid", 32'(flr_req_tvalid), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err_unexp_rsp), 32'd0);
        chk("rst_stat_issued", stat_issued, 32'd0);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int n, k;
        int cand [$];
        cyc = 0;
        quiet();
        do_reset();

        // PF FLR round trip
        cmd(1, 0, 0);
        chk("pf_req_beat", 32'(flr_req_tvalid), 32'd1);
        chk("pf_out1", 32'(outstanding), 32'd1);
        idle(9);
        rsp(1, 0, 0);
        chk("pf_done_ok", {30'd0, done_status}, 32'd0);
        chk("pf_out0", 32'(outstanding), 32'd0);

        // Table fill and release of one slot
        for (int v = 0; v < 4; v++) cmd(0, 1, v);
        #1; chk("fill_ready_low", 32'(cmd_ready), 32'd0);
        rsp(0, 1, 2);
        chk("fill_done_vf2", 32'(done_vf), 32'd2);
        #1; chk("fill_ready_back", 32'(cmd_ready), 32'd1);
        rsp(0, 1, 0); rsp(0, 1, 1); rsp(0, 1, 3);
        idle(2);

        // Duplicate command
        cmd(0, 1, 5);
        cmd(0, 1, 5);
        chk("dup_no_req", 32'(flr_req_tvalid), 32'd0);
        chk("dup_status", {30'd0, done_status}, 32'd2);
        rsp(0, 1, 5);
        idle(2);

        // Timeout latency, then a late response
        cmd(1, 1, 3);
        n = 0;
        while (!done_valid && n < 200) begin tick(); n++; end
        chk("tmo_latency", 32'(n), 32'd101);
        chk("tmo_status", {30'd0, done_status}, 32'd1);
        rsp(1, 1, 3);
        chk("late_rsp_err", 32'(err_unexp_rsp), 32'd1);
        err_clear = 1'b1;
        rsp(0, 0, 7);
        chk("clr_vs_new_err", 32'(err_unexp_rsp), 32'd1);
        tick();
        err_clear = 1'b0;
        chk("err_cleared", 32'(err_unexp_rsp), 32'd0);

        // Response on the expiry cycle beats the timeout
        cmd(0, 0, 0);
        idle(TMO - 1);
        rsp(0, 0, 0);
        chk("coll_done_ok", {31'd0, done_valid} + {30'd0, done_status}, 32'd1);
        idle(3);
        cmd_valid = 1'b1; cmd_pf = 1'b1; cmd_vf_active = 1'b0;
        flr_rsp_tvalid = 1'b1; flr_rsp_pf = 1'b1; flr_rsp_vf_active = 1'b1; flr_rsp_vf = 3'd6;
        #1; chk("coll_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        quiet();
        err_clear = 1'b1; tick(); err_clear = 1'b0;

        // Reset with entries in flight
        cmd(0, 0, 0); cmd(1, 0, 0); cmd(1, 1, 4);
        chk("pre_rst_out", 32'(outstanding), 32'd3);
        do_reset();
        idle(5);
        chk("post_rst_out", 32'(outstanding), 32'd0);

        // Random traffic
        for (int t = 0; t < 2500; t++) begin
            cmd_valid     = ($urandom_range(0, 99) < 40);
            cmd_pf        = 1'($urandom_range(0, 1));
            cmd_vf_active = 1'($urandom_range(0, 1));
            cmd_vf        = 3'($urandom_range(0, 7));
            flr_rsp_tvalid = ($urandom_range(0, 99) < 8);
            cand = {};
            for (int i = 0; i < NOUT; i++) if (m_busy[i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
                k = cand[$urandom_range(0, cand.size() - 1)];
                flr_rsp_pf = 1'(m_pf[k]); flr_rsp_vf_active = 1'(m_va[k]); flr_rsp_vf = 3'(m_vf[k]);
            end else begin
                flr_rsp_pf = 1'($urandom_range(0, 1));
                flr_rsp_vf_active = 1'($urandom_range(0, 1));
                flr_rsp_vf = 3'($urandom_range(0, 7));
            end
            err_clear = ($urandom_range(0, 99) < 5);
            tick();
        end
        quiet();
        idle(TMO + 10);

`ifdef FLR_INIT_STATS_EN
        chk("stat_issued", stat_issued, 32'(m_issued));
        chk("stat_ok", stat_ok, 32'(m_ok));
        chk("stat_timeout", stat_timeout, 32'(m_to));
`else
        chk("stat_issued_tied", stat_issued, 32'd0);
        chk("stat_ok_tied", stat_ok, 32'd0);
        chk("stat_timeout_tied", stat_timeout, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
